axis_usb_packetiser: RTL and testbench
======================================

// Module: axis_usb_packetiser
// PURPOSE
// - Downstream of the frame-buffering async FIFO, in the USB (m_) clock domain.
// - Cuts each AXI-Stream frame into USB bulk-IN packets of at most MAX_PKT bytes.
//   m_tlast marks every packet end; a frame end also ends its final packet.
// - Appends a zero-length packet (ZLP) when a frame length is a non-zero exact
//   multiple of MAX_PKT, so the host can detect end-of-transfer.
// PARAMETERS
// - WIDTH    8    data width (bits); one beat = one byte
// - MAX_PKT  512  max packet payload bytes (64 FS, 512 HS); power of two, >=8
// - ZLP_EN   1    1: emit ZLP after exact-multiple frames; 0: never emit ZLP
// PORTS
// - clock     in   1      single clock, all logic rising-edge
// - reset_n   in   1      synchronous, active-low reset
// - s_tvalid  in   1      upstream (FIFO) beat valid
// - s_tready  out  1      upstream beat accepted when s_tvalid & s_tready
// - s_tlast   in   1      last byte of frame
// - s_tdata   in   WIDTH  frame byte
// - m_tvalid  out  1      packet beat valid
// - m_tready  in   1      downstream (USB IN endpoint) ready
// - m_tlast   out  1      last beat of USB packet
// - m_tkeep   out  1      1 = data byte; 0 only on ZLP beat
// - m_tdata   out  WIDTH  packet byte; 0 on ZLP beat
// BEHAVIOUR
// - Reset (reset_n=0 at clock edge): m_tvalid=0, m_tlast=0, m_tkeep=0,
//   m_tdata=0, s_tready=0, count=0, state=XFER.
//   Reset mid-frame or mid-ZLP discards all held beats; nothing is replayed.
// - Latency: 1 cycle s->m when the output register is empty.
//   Full throughput, 1 beat/cycle, under continuous valid/ready.
// - AXIS rules:
//   - m_tvalid never drops, and m_tdata/m_tlast/m_tkeep never change, until
//     m_tvalid & m_tready.
//   - s_tready has no combinational path from s_tvalid.
// - count (clog2(MAX_PKT) bits) = bytes already emitted in the current packet.
// - States:
//   - XFER, on each accepted s beat:
//     - m_tdata=s_tdata, m_tkeep=1.
//     - m_tlast = s_tlast | (count==MAX_PKT-1).
//     - count <= m_tlast ? 0 : count+1.
//     - s_tlast & count==MAX_PKT-1 & ZLP_EN -> go to ZLP.
//   - ZLP: s_tready=0.
//     - Once the final data beat leaves the output register, load
//       m_tvalid=1, m_tlast=1, m_tkeep=0, m_tdata=0.
//     - When that beat is accepted -> XFER.
// - Boundaries:
//   - Single-byte frame -> one beat, m_tlast=1, no ZLP.
//   - Frame of MAX_PKT-1 bytes -> one packet, no ZLP.
//   - Frame of k*MAX_PKT bytes (k>=1): k packets, then one ZLP (if ZLP_EN).
//   - Frame of k*MAX_PKT+r bytes (0<r<MAX_PKT): k full packets + one r-byte
//     packet, no ZLP.
//   - count wraps to 0 only via the m_tlast rule; it never exceeds MAX_PKT-1.
//   - A new frame's first byte can be accepted in the cycle the previous
//     frame's last beat is consumed, except in the ZLP case.
//   - m_tready held low: the pipeline stalls, s_tready=0 once output+skid are full.
// STRUCTURE
// - Shared package usb_defs_pkg:
//   - USB_FS_MAX_BULK=64, USB_HS_MAX_BULK=512
//   - state encoding localparams: ST_XFER, ST_ZLP
// - One sub-module: axis_skid_register.
//   - 2-entry register slice, width WIDTH+2 ({tkeep,tlast,tdata}).
//   - Drives m_*; provides registered s_tready.
// - Top level holds count, state and ZLP insertion mux (~150-250 lines total).
// TESTING
// - MAX_PKT=8, 3-byte frame, m_tready=1 -> 3 beats, m_tlast on beat 3 only;
//   m_tkeep=1 on all beats.
// - MAX_PKT=8, 20-byte frame -> packets of 8,8,4 bytes; m_tlast on beats 8,16,20;
//   no ZLP.
// - MAX_PKT=8, ZLP_EN=1, 16-byte frame -> 8,8, then beat m_tkeep=0, m_tlast=1,
//   m_tdata=0.
//   With ZLP_EN=0, the same frame -> 8,8 only.
// - Random m_tready (50%) and s_tvalid gaps, 200 frames of length 1..40
//   -> byte order preserved.
//   - Packet sizes follow the boundary rules.
//   - AXIS stability assertions hold.
// - Assert reset_n=0 mid-packet (count=5) and during a pending ZLP
//   -> next cycle all outputs 0.
//   - The next 3-byte frame produces a 3-byte packet with no stale beats.

Source files
------------

// File: rtl/usb_defs_pkg.sv
// usb_defs_pkg: USB bulk packet sizes and packetiser state encoding
package usb_defs_pkg;
  localparam int USB_FS_MAX_BULK = 64;
  localparam int USB_HS_MAX_BULK = 512;
  typedef enum logic {ST_XFER = 1'b0, ST_ZLP = 1'b1} state_t;
endpackage

// File: rtl/axis_usb_packetiser_if.sv
// axis_usb_packetiser_if: byte-wide AXI-Stream link with keep and last
interface axis_usb_packetiser_if #(parameter int WIDTH = 8);
  logic             tvalid;
  logic             tready;
  logic             tlast;
  logic             tkeep;
  logic [WIDTH-1:0] tdata;
  modport master(output tvalid, tlast, tkeep, tdata, input tready);
  modport slave(input tvalid, tlast, tkeep, tdata, output tready);
endinterface

// File: rtl/axis_skid_register.sv
// axis_skid_register: 2-entry register slice with registered upstream ready
module axis_skid_register #(
  parameter int W = 10
) (
  input  logic         clock,
  input  logic         reset_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data
);
  logic         skid_valid, skid_valid_n, load, accept;
  logic [W-1:0] skid_data;
  assign load   = !out_valid || out_ready;
  assign accept = in_valid && in_ready;
  always_comb skid_valid_n = load ? 1'b0 : (skid_valid || accept);
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      out_valid  <= 1'b0;
      out_data   <= '0;
      skid_valid <= 1'b0;
      skid_data  <= '0;
      in_ready   <= 1'b0;
    end else begin
      skid_valid <= skid_valid_n;
      in_ready   <= !skid_valid_n;
      if (load) begin
        out_valid <= skid_valid || accept;
        if (skid_valid) out_data <= skid_data;
        else if (accept) out_data <= in_data;
      end else if (accept) begin
        skid_data <= in_data;
      end
    end
  end
endmodule

// File: rtl/axis_usb_packetiser.sv
// axis_usb_packetiser: cuts AXI-Stream frames into USB bulk-IN packets, adding a ZLP
module axis_usb_packetiser
  import usb_defs_pkg::*;
#(
  parameter int WIDTH   = 8,
  parameter int MAX_PKT = USB_HS_MAX_BULK,
  parameter int ZLP_EN  = 1
) (
  input logic                  clock,
  input logic                  reset_n,
  axis_usb_packetiser_if.slave  s,
  axis_usb_packetiser_if.master m
);
  localparam int CW = $clog2(MAX_PKT);
  state_t           state, state_n;
  logic [CW-1:0]    count, count_n;
  logic             zlp_loaded, zlp_loaded_n;
  logic             in_valid, in_ready, out_valid, pkt_end, full_pkt;
  logic [WIDTH+1:0] in_data, out_data;
  assign full_pkt = count == CW'(MAX_PKT - 1);
  assign pkt_end  = s.tlast || full_pkt;
  assign s.tready = state == ST_XFER && in_ready;
  // In ZLP the slice input carries the single zero-length beat, queued behind the final data beat
  always_comb begin
    in_valid     = state == ST_XFER ? s.tvalid : !zlp_loaded;
    in_data      = state == ST_XFER ? {1'b1, pkt_end, s.tdata} : {2'b01, {WIDTH{1'b0}}};
    state_n      = state;
    count_n      = count;
    zlp_loaded_n = zlp_loaded;
    if (state == ST_XFER && s.tvalid && s.tready) begin
      count_n = pkt_end ? '0 : count + 1'b1;
      if (s.tlast && full_pkt && ZLP_EN != 0) state_n = ST_ZLP;
    end
    if (state == ST_ZLP) begin
      if (in_valid && in_ready) zlp_loaded_n = 1'b1;
      if (zlp_loaded && out_valid && m.tready && !out_data[WIDTH+1]) begin
        state_n      = ST_XFER;
        zlp_loaded_n = 1'b0;
      end
    end
  end
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state      <= ST_XFER;
      count      <= '0;
      zlp_loaded <= 1'b0;
    end else begin
      state      <= state_n;
      count      <= count_n;
      zlp_loaded <= zlp_loaded_n;
    end
  end
  axis_skid_register #(.W(WIDTH + 2)) u_skid (
    .clock    (clock),
    .reset_n  (reset_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (in_data),
    .out_valid(out_valid),
    .out_ready(m.tready),
    .out_data (out_data)
  );
  assign m.tvalid = out_valid;
  assign {m.tkeep, m.tlast, m.tdata} = out_data;
endmodule

// File: tb/tb_axis_usb_packetiser.sv
// tb_axis_usb_packetiser: scoreboard bench for the USB packetiser with MAX_PKT=8
module tb_axis_usb_packetiser;
  localparam int MP = 8;
  logic clock = 1'b0;
  logic reset_n = 1'b0;
  always #5 clock = ~clock;
  axis_usb_packetiser_if #(8) s (), m (), s1 (), m1 ();
  axis_usb_packetiser #(.WIDTH(8), .MAX_PKT(MP), .ZLP_EN(1)) dut (
    .clock(clock), .reset_n(reset_n), .s(s), .m(m));
  axis_usb_packetiser #(.WIDTH(8), .MAX_PKT(MP), .ZLP_EN(0)) dut1 (
    .clock(clock), .reset_n(reset_n), .s(s1), .m(m1));
  int         cmp_cnt = 0, err_cnt = 0, sent = 0, rdy_mode = 0, junk, base;
  logic [9:0] q[$], q1[$], hword;
  bit         en1 = 0, hold = 0;
  // dut1 sees a copy of every beat dut accepts, only while en1 is set
  assign s1.tvalid = en1 && s.tvalid && s.tready;
  assign s1.tlast  = s.tlast;
  assign s1.tdata  = s.tdata;
  assign s1.tkeep  = 1'b1;
  assign m1.tready = 1'b1;
  task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
    cmp_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic step(int n);
    repeat (n) @(posedge clock);
    #1;
  endtask
  always @(posedge clock) begin
    #2;
    m.tready = rdy_mode == 0 ? 1'b1 : rdy_mode == 1 ? 1'($urandom_range(0, 1)) : 1'b0;
  end
  always @(negedge clock) begin
    if (!reset_n) hold = 0;
    else begin
      if (hold) begin
        check("stable_valid", m.tvalid, 1);
        check("stable_word", {m.tkeep, m.tlast, m.tdata}, hword);
      end
      if (m.tvalid && m.tready) begin
        if (q.size() == 0) check("unexpected_beat", 1, 0);
        else check("beat", {m.tkeep, m.tlast, m.tdata}, q.pop_front());
      end
      hold  = m.tvalid && !m.tready;
      hword = {m.tkeep, m.tlast, m.tdata};
    end
  end
  always @(negedge clock) begin
    if (reset_n && m1.tvalid && m1.tready) begin
      if (q1.size() == 0) check("dut1_unexpected_beat", 1, 0);
      else check("dut1_beat", {m1.tkeep, m1.tlast, m1.tdata}, q1.pop_front());
    end
  end
  task automatic send_frame(int len, int n, bit gaps, output int cyc);
    cyc = 0;
    for (int i = 0; i < n; i++) begin
      logic [7:0] d;
      logic       lst;
      bit         ok;
      int         w;
      if (gaps) while ($urandom_range(0, 2) == 0) begin
        s.tvalid = 1'b0;
        step(1);
      end
      d = 8'($urandom);
      s.tvalid = 1'b1;
      s.tdata  = d;
      s.tlast  = i == len - 1;
      ok = 0;
      w  = 0;
      while (!ok) begin
        @(negedge clock);
        ok = s.tready;
        step(1);
        cyc++;
        if (!ok && ++w > 500) begin
          check("accept_timeout", 0, 1);
          s.tvalid = 1'b0;
          return;
        end
      end
      lst = (i == len - 1) || (i % MP == MP - 1);
      q.push_back({1'b1, lst, d});
      if (en1) q1.push_back({1'b1, lst, d});
      if (i == len - 1 && len % MP == 0) q.push_back(10'h100);
      sent++;
    end
    s.tvalid = 1'b0;
    s.tlast  = 1'b0;
  endtask
  task automatic drain();
    int w = 0;
    while ((q.size() != 0 || q1.size() != 0) && w < 3000) begin
      step(1);
      w++;
    end
    check("drain", q.size() + q1.size(), 0);
    step(4);
  endtask
  task automatic check_zero(string tag);
    check({tag, "_m_tvalid"}, m.tvalid, 0);
    check({tag, "_m_tlast"}, m.tlast, 0);
    check({tag, "_m_tkeep"}, m.tkeep, 0);
    check({tag, "_m_tdata"}, m.tdata, 0);
    check({tag, "_s_tready"}, s.tready, 0);
  endtask
  task automatic do_reset(string tag);
    reset_n = 1'b0;
    step(1);
    check_zero(tag);
    q.delete();
    q1.delete();
    reset_n = 1'b1;
    step(1);
  endtask
  initial begin
    s.tvalid = 1'b0;
    s.tlast  = 1'b0;
    s.tkeep  = 1'b1;
    s.tdata  = '0;
    m.tready = 1'b1;
    step(3);
    check_zero("reset");
    reset_n = 1'b1;
    step(2);
    // single-byte frame: one-cycle latency, one beat with tlast
    s.tvalid = 1'b1;
    s.tdata  = 8'hA5;
    s.tlast  = 1'b1;
    @(negedge clock);
    check("idle_s_tready", s.tready, 1);
    step(1);
    q.push_back(10'h3A5);
    s.tvalid = 1'b0;
    s.tlast  = 1'b0;
    check("latency_m_tvalid", m.tvalid, 1);
    check("latency_m_tdata", m.tdata, 8'hA5);
    drain();
    send_frame(3, 3, 0, junk);
    drain();
    send_frame(20, 20, 0, junk);
    check("throughput_cycles", junk, 20);
    drain();
    send_frame(7, 7, 0, junk);
    drain();
    en1 = 1;
    send_frame(16, 16, 0, junk);
    en1 = 0;
    drain();
    // downstream stall: output and skid fill, then upstream ready drops
    rdy_mode = 2;
    step(1);
    base = sent;
    fork send_frame(4, 4, 0, junk); join_none
    step(8);
    check("stall_accepts", sent - base, 2);
    check("stall_s_tready", s.tready, 0);
    check("stall_m_tvalid", m.tvalid, 1);
    check("stall_m_word", {m.tkeep, m.tlast, m.tdata}, q[0]);
    rdy_mode = 0;
    wait fork;
    drain();
    send_frame(10, 5, 0, junk);
    drain();
    do_reset("rst_mid_pkt");
    send_frame(3, 3, 0, junk);
    drain();
    base = sent;
    fork send_frame(8, 8, 0, junk); join_none
    for (int w = 0; w < 500 && sent < base + 7; w++) step(1);
    rdy_mode = 2;
    wait fork;
    step(2);
    check("zlp_pending_m_tvalid", m.tvalid, 1);
    check("zlp_pending_word", {m.tkeep, m.tlast, m.tdata}, q[0]);
    do_reset("rst_zlp");
    rdy_mode = 0;
    send_frame(3, 3, 0, junk);
    drain();
    rdy_mode = 1;
    for (int f = 0; f < 200; f++) begin
      int len = $urandom_range(1, 40);
      send_frame(len, len, 1, junk);
    end
    drain();
    rdy_mode = 0;
    step(4);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
    $finish;
  end
endmodule
